// File: rtl/digit_pkg.sv
// Shared constants and state encoding for the digit result stabilizer.
// Imported by the top and the vsync edge detector.
package digit_pkg;

  localparam int          NUM_DIGIT    = 6;
  localparam logic [3:0]  BLANK_NIBBLE = 4'hF;
  localparam logic [23:0] BLANK_WORD   = 24'hFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED,
    LOST
  } state_t;

endpackage

// File: rtl/vsync_edge_det.sv
// Registers frame sync once and flags the edge into the active level.
// smp is a single-cycle strobe per frame.
module vsync_edge_det
  import digit_pkg::*;
#(
  parameter logic VS_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic smp
);

  logic vs_d;

  // Reset to the active level so a sync already asserted at reset is not a frame.
  always_ff @(posedge clk) begin
    if (rst) vs_d <= VS_ACTIVE;
    else     vs_d <= vsync;
  end

  assign smp = (vs_d != VS_ACTIVE) && (vsync == VS_ACTIVE);

endmodule

// File: rtl/digit_result_stabilizer.sv
// Debounces per-frame BCD recognition results before the segment driver.
// Commits after N identical frames, blanks when frames stop arriving.
module digit_result_stabilizer
  import digit_pkg::*;
#(
  parameter int          STABLE_FRAMES  = 3,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd9000000,
  parameter logic        VS_ACTIVE      = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_vsync,
  input  logic [23:0] digit_in,
  output logic [23:0] digit_out,
  output logic        digit_valid,
  output logic        digit_upd,
  output logic        sig_lost
);

  localparam logic [3:0] SF = 4'(STABLE_FRAMES);

  state_t      state;
  logic        smp;
  logic [23:0] san;
  logic [23:0] cand;
  logic [3:0]  match_cnt;
  logic [3:0]  cnt_inc;
  logic [23:0] timer;
  logic        run_done;
  logic        tracking;
  logic        timeout;

  vsync_edge_det #(
    .VS_ACTIVE(VS_ACTIVE)
  ) u_edge (
    .clk  (clk),
    .rst  (rst),
    .vsync(frame_vsync),
    .smp  (smp)
  );

  always_comb begin
    san = BLANK_WORD;
    for (int i = 0; i < NUM_DIGIT; i++) begin
      san[i*4 +: 4] = (digit_in[i*4 +: 4] > 4'd9) ?
                      BLANK_NIBBLE : digit_in[i*4 +: 4];
    end
  end

  assign cnt_inc  = (match_cnt >= SF) ? SF : match_cnt + 4'd1;
  assign tracking = (state == TRACK) || (state == LOCKED);
  assign timeout  = tracking && (timer == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      digit_out   <= BLANK_WORD;
      digit_valid <= 1'b0;
      digit_upd   <= 1'b0;
      sig_lost    <= 1'b0;
      cand        <= BLANK_WORD;
      match_cnt   <= '0;
      timer       <= '0;
      run_done    <= 1'b0;
    end else begin
      digit_upd <= 1'b0;
      run_done  <= 1'b0;
      // run_done marks the sample that completed a run; commit one cycle later.
      if (run_done) begin
        if (cand != digit_out) begin
          digit_out <= cand;
          digit_upd <= 1'b1;
        end
        digit_valid <= (cand != BLANK_WORD);
      end
      if (smp) begin
        timer    <= '0;
        sig_lost <= 1'b0;
        if (san == cand) begin
          match_cnt <= cnt_inc;
          run_done  <= (match_cnt != SF) && (cnt_inc == SF);
        end else begin
          cand      <= san;
          match_cnt <= 4'd1;
          run_done  <= (SF == 4'd1);
        end
        unique case (state)
          IDLE, LOST: state <= TRACK;
          LOCKED:     if (san != cand) state <= TRACK;
          TRACK:      ;
        endcase
      end else if (timeout) begin
        state       <= LOST;
        sig_lost    <= 1'b1;
        digit_out   <= BLANK_WORD;
        digit_valid <= 1'b0;
        digit_upd   <= 1'b0;
        cand        <= BLANK_WORD;
        match_cnt   <= '0;
      end else begin
        if (tracking && timer != TIMEOUT_CYCLES) timer <= timer + 24'd1;
        if (run_done && state == TRACK) state <= LOCKED;
      end
    end
  end

endmodule

// File: tb/tb_digit_result_stabilizer.sv
// Directed bench for digit_result_stabilizer with a short timeout.
// Frames are single low pulses on frame_vsync with garbage data between strobes.
module tb_digit_result_stabilizer;

  localparam int TO = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_vsync;
  logic [23:0] digit_in;
  logic [23:0] digit_out;
  logic        digit_valid;
  logic        digit_upd;
  logic        sig_lost;

  int errors = 0;
  int checks = 0;
  int upd_cnt = 0;
  bit lost_seen = 1'b0;

  always #5 clk = ~clk;

  digit_result_stabilizer #(
    .STABLE_FRAMES (3),
    .TIMEOUT_CYCLES(24'(TO)),
    .VS_ACTIVE     (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_vsync(frame_vsync),
    .digit_in   (digit_in),
    .digit_out  (digit_out),
    .digit_valid(digit_valid),
    .digit_upd  (digit_upd),
    .sig_lost   (sig_lost)
  );

  always @(negedge clk) begin
    if (digit_upd) upd_cnt++;
    if (sig_lost) lost_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the strobe edge.
  task automatic frame(input logic [23:0] d);
    digit_in    = d;
    frame_vsync = 1'b0;
    @(negedge clk);
    frame_vsync = 1'b1;
    digit_in    = 24'h999999;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input logic [23:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      frame(d);
      gap(8);
    end
  endtask

  initial begin
    rst         = 1'b1;
    frame_vsync = 1'b1;
    digit_in    = 24'h000000;
    gap(3);
    chk("rst_out", 32'(digit_out), 32'hFFFFFF);
    chk("rst_valid", 32'(digit_valid), 0);
    chk("rst_upd", 32'(digit_upd), 0);
    chk("rst_lost", 32'(sig_lost), 0);
    rst = 1'b0;
    gap(TO + 10);
    chk("idle_no_timeout", 32'(sig_lost), 0);

    // 1: three identical frames, check 2-clk commit latency
    frames(24'h123456, 2);
    frame(24'h123456);
    chk("t1_before", 32'(digit_out), 32'hFFFFFF);
    gap(1);
    chk("t1_out", 32'(digit_out), 32'h123456);
    chk("t1_upd", 32'(digit_upd), 1);
    chk("t1_valid", 32'(digit_valid), 1);
    gap(1);
    chk("t1_upd_off", 32'(digit_upd), 0);
    gap(8);
    chk("t1_updcnt", 32'(upd_cnt), 1);

    // 2: flicker must not commit
    frames(24'h123457, 1);
    frames(24'h123456, 1);
    frames(24'h123457, 2);
    chk("t2_hold", 32'(digit_out), 32'h123456);
    frames(24'h123457, 1);
    chk("t2_out", 32'(digit_out), 32'h123457);
    chk("t2_updcnt", 32'(upd_cnt), 2);

    // 3: invalid nibbles become blanks
    frames(24'h12AB56, 3);
    chk("t3_out", 32'(digit_out), 32'h12FF56);
    chk("t3_valid", 32'(digit_valid), 1);

    // all-blank result commits without being a loss
    frames(24'hAAAAAA, 3);
    chk("blank_out", 32'(digit_out), 32'hFFFFFF);
    chk("blank_valid", 32'(digit_valid), 0);
    chk("blank_lost", 32'(sig_lost), 0);
    chk("blank_updcnt", 32'(upd_cnt), 4);

    // 5: long steady run gives one pulse; smp at timer limit wins
    frames(24'h654321, 10);
    chk("t5_out", 32'(digit_out), 32'h654321);
    chk("t5_updcnt", 32'(upd_cnt), 5);
    frame(24'h654321);
    gap(TO);
    frame(24'h654321);
    gap(TO);
    frame(24'h654321);
    gap(4);
    chk("t5_edge_nolost", 32'(lost_seen), 0);
    chk("t5_edge_out", 32'(digit_out), 32'h654321);
    frame(24'h654321);
    gap(TO + 1);
    frame(24'h654321);
    gap(4);
    chk("t5_late_lost", 32'(lost_seen), 1);
    chk("t5_late_out", 32'(digit_out), 32'hFFFFFF);

    // 4: timeout from LOCKED, then recovery needs 3 frames
    frames(24'h123456, 3);
    chk("t4_locked", 32'(digit_out), 32'h123456);
    chk("t4_updcnt", 32'(upd_cnt), 6);
    gap(TO + 5);
    chk("t4_lost", 32'(sig_lost), 1);
    chk("t4_out", 32'(digit_out), 32'hFFFFFF);
    chk("t4_valid", 32'(digit_valid), 0);
    frame(24'h123456);
    chk("t4_lost_clr", 32'(sig_lost), 0);
    gap(8);
    frames(24'h123456, 1);
    chk("t4_nocommit", 32'(digit_valid), 0);
    chk("t4_nocommit_out", 32'(digit_out), 32'hFFFFFF);
    frames(24'h123456, 1);
    chk("t4_recommit", 32'(digit_out), 32'h123456);
    chk("t4_recommit_v", 32'(digit_valid), 1);

    // 6: reset at match_cnt = 2 discards the run
    frames(24'h111111, 2);
    rst = 1'b1;
    gap(1);
    chk("t6_out", 32'(digit_out), 32'hFFFFFF);
    chk("t6_valid", 32'(digit_valid), 0);
    chk("t6_upd", 32'(digit_upd), 0);
    chk("t6_lost", 32'(sig_lost), 0);
    rst = 1'b0;
    gap(2);
    frames(24'h111111, 2);
    chk("t6_nocommit", 32'(digit_out), 32'hFFFFFF);
    frames(24'h111111, 1);
    chk("t6_commit", 32'(digit_out), 32'h111111);
    chk("t6_valid1", 32'(digit_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
